// File: rtl/tile_seq_ctrl_pkg.sv
// Shared types, default parameter values and a width helper for tile_seq_ctrl.
package tile_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    localparam int unsigned DEF_LANES     = 5;
    localparam int unsigned DEF_PIX_W     = 5;
    localparam int unsigned DEF_IN_BEATS  = 80;
    localparam int unsigned DEF_OUT_BEATS = 324;
    localparam int unsigned DEF_PACK_W    = 8;
    localparam int unsigned DEF_CLR_CYC   = 2;
    localparam int unsigned DEF_TILES     = 0;

    // Ceil(log2(n)), never less than 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/tile_seq_ctrl_edge_packer.sv
// Packs serial edge bits into PACK_W-bit words, first bit in the LSB.
// A word is emitted the cycle after its completing bit; the tile's final
// bit closes the word early, leaving unused MSBs zero, and flags out_last.
module edge_packer
    import tile_seq_ctrl_pkg::*;
#(
    parameter int unsigned PACK_W = DEF_PACK_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bit_vld,
    input  logic              bit_val,
    input  logic              bit_last,
    output logic              out_valid,
    output logic [PACK_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned FILL_W = clog2(PACK_W);

    logic [PACK_W-1:0] pack;
    logic [PACK_W-1:0] word_nx;
    logic [FILL_W-1:0] fill;
    logic              full;

    // Current word with the incoming bit dropped into its slot.
    always_comb begin
        word_nx       = pack;
        word_nx[fill] = bit_val;
    end

    assign full = (fill == FILL_W'(PACK_W - 1));

    // Accumulate bits; emit on a full word or on the tile's last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (bit_vld) begin
                if (full || bit_last) begin
                    out_valid <= 1'b1;
                    out_data  <= word_nx;
                    out_last  <= bit_last;
                    pack      <= '0;
                    fill      <= '0;
                end else begin
                    pack <= word_nx;
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tile_seq_ctrl.sv
// Tile sequencer: clears the edge core, streams IN_BEATS pixel beats into it,
// collects OUT_BEATS edge bits back, packs them and reports per-tile stats.
module tile_seq_ctrl
    import tile_seq_ctrl_pkg::*;
#(
    parameter int unsigned LANES     = DEF_LANES,
    parameter int unsigned PIX_W     = DEF_PIX_W,
    parameter int unsigned IN_BEATS  = DEF_IN_BEATS,
    parameter int unsigned OUT_BEATS = DEF_OUT_BEATS,
    parameter int unsigned PACK_W    = DEF_PACK_W,
    parameter int unsigned CLR_CYC   = DEF_CLR_CYC,
    parameter int unsigned TILES     = DEF_TILES
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               src_valid,
    output logic                               src_ready,
    input  logic [LANES*PIX_W-1:0]             src_pix,
    output logic                               core_rst,
    output logic [LANES*PIX_W-1:0]             core_pix,
    output logic                               core_pix_vld,
    output logic                               core_load_end,
    input  logic                               core_readable,
    input  logic                               core_edge,
    output logic                               out_valid,
    output logic [PACK_W-1:0]                  out_data,
    output logic                               out_last,
    output logic [clog2(OUT_BEATS+1)-1:0]      edge_cnt,
    output logic                               cnt_valid,
    output logic [15:0]                        tile_idx,
    output logic                               done,
    output logic                               err_ovf
);

    localparam int unsigned BEAT_W = clog2(IN_BEATS + 1);
    localparam int unsigned BIT_W  = clog2(OUT_BEATS + 1);
    localparam int unsigned CLR_W  = clog2(CLR_CYC + 1);

    state_t            state, state_nx;
    logic [CLR_W-1:0]  clr_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  edge_acc;
    logic              beat_take, last_beat, bit_take, last_bit;

    assign beat_take = (state == LOAD) && src_valid;
    assign last_beat = beat_take && (beat_cnt == BEAT_W'(IN_BEATS - 1));
    assign bit_take  = (state == DRAIN) && core_readable;
    assign last_bit  = bit_take && (bit_cnt == BIT_W'(OUT_BEATS - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic; tile_idx is already bumped when FLUSH is reached.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (src_valid) state_nx = CLEAR;
            CLEAR:   if (clr_cnt == CLR_W'(CLR_CYC - 1)) state_nx = LOAD;
            LOAD:    if (last_beat) state_nx = DRAIN;
            DRAIN:   if (last_bit) state_nx = FLUSH;
            FLUSH:   state_nx = ((TILES != 0) && (tile_idx == 16'(TILES))) ? DONE : CLEAR;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        src_ready = (state == LOAD);
        core_rst  = (state == CLEAR);
        done      = (state == DONE);
    end

    // Counters, pixel pipeline and tile statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt       <= '0;
            beat_cnt      <= '0;
            bit_cnt       <= '0;
            edge_acc      <= '0;
            core_pix      <= '0;
            core_pix_vld  <= 1'b0;
            core_load_end <= 1'b0;
            edge_cnt      <= '0;
            cnt_valid     <= 1'b0;
            tile_idx      <= '0;
            err_ovf       <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clr_cnt       <= clr_cnt + CLR_W'(1);
                beat_cnt      <= '0;
                bit_cnt       <= '0;
                edge_acc      <= '0;
                core_load_end <= 1'b0;
            end else begin
                clr_cnt <= '0;
            end
            core_pix_vld <= beat_take;
            if (beat_take) begin
                core_pix <= src_pix;
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            if (last_beat) core_load_end <= 1'b1;
            if (bit_take) begin
                bit_cnt  <= bit_cnt + BIT_W'(1);
                edge_acc <= edge_acc + BIT_W'(core_edge);
            end
            // Tile statistics are registered on the last bit so they are
            // presented during the FLUSH cycle alongside out_last.
            cnt_valid <= last_bit;
            if (last_bit) begin
                edge_cnt <= edge_acc + BIT_W'(core_edge);
                tile_idx <= tile_idx + 16'd1;
            end
            if (core_readable && (state != DRAIN)) err_ovf <= 1'b1;
        end
    end

    edge_packer #(
        .PACK_W (PACK_W)
    ) u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_vld   (bit_take),
        .bit_val   (core_edge),
        .bit_last  (last_bit),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Scoreboard bench for tile_seq_ctrl: drivers push expected beats, words and
// tile statistics into queues; monitors pop and compare on DUT strobes.
module tb_tile_seq_ctrl;

    localparam int LANES     = 5;
    localparam int PIX_W     = 5;
    localparam int IN_BEATS  = 80;
    localparam int OUT_BEATS = 324;
    localparam int PACK_W    = 8;
    localparam int CLR_CYC   = 2;
    localparam int TILES     = 3;
    localparam int PW        = LANES * PIX_W;
    localparam int CW        = $clog2(OUT_BEATS + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic [PW-1:0]     src_pix = '0;
    logic              core_rst;
    logic [PW-1:0]     core_pix;
    logic              core_pix_vld;
    logic              core_load_end;
    logic              core_readable = 1'b0;
    logic              core_edge = 1'b0;
    logic              out_valid;
    logic [PACK_W-1:0] out_data;
    logic              out_last;
    logic [CW-1:0]     edge_cnt;
    logic              cnt_valid;
    logic [15:0]       tile_idx;
    logic              done;
    logic              err_ovf;

    tile_seq_ctrl #(
        .LANES     (LANES),
        .PIX_W     (PIX_W),
        .IN_BEATS  (IN_BEATS),
        .OUT_BEATS (OUT_BEATS),
        .PACK_W    (PACK_W),
        .CLR_CYC   (CLR_CYC),
        .TILES     (TILES)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_pix       (src_pix),
        .core_rst      (core_rst),
        .core_pix      (core_pix),
        .core_pix_vld  (core_pix_vld),
        .core_load_end (core_load_end),
        .core_readable (core_readable),
        .core_edge     (core_edge),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .edge_cnt      (edge_cnt),
        .cnt_valid     (cnt_valid),
        .tile_idx      (tile_idx),
        .done          (done),
        .err_ovf       (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [PW-1:0] pix; logic last; } beat_t;
    typedef struct packed { logic [PACK_W-1:0] data; logic last; } word_t;
    typedef struct packed { logic [CW-1:0] cnt; logic [15:0] idx; } stat_t;

    beat_t beat_q[$];
    word_t word_q[$];
    stat_t stat_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          pix_seen = 0;
    int          rst_run = 0;
    bit          err_exp = 1'b0;
    int          tiles_done = 0;
    logic [CW-1:0] last_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Pixel monitor.
    always @(negedge clk) begin
        beat_t b;
        if (reset_n && core_pix_vld) begin
            pix_seen++;
            if (beat_q.size() == 0) fail("spurious_core_pix_vld");
            else begin
                b = beat_q.pop_front();
                chk("core_pix", core_pix, b.pix);
                chk("core_load_end", core_load_end, b.last);
            end
        end
    end

    // Packed-word monitor.
    always @(negedge clk) begin
        word_t w;
        if (reset_n && out_valid) begin
            if (word_q.size() == 0) fail("spurious_out_valid");
            else begin
                w = word_q.pop_front();
                chk("out_data", out_data, w.data);
                chk("out_last", out_last, w.last);
            end
        end
    end

    // Tile statistics monitor.
    always @(negedge clk) begin
        stat_t s;
        if (reset_n && cnt_valid) begin
            if (stat_q.size() == 0) fail("spurious_cnt_valid");
            else begin
                s = stat_q.pop_front();
                chk("edge_cnt", edge_cnt, s.cnt);
                chk("tile_idx", tile_idx, s.idx);
            end
        end
    end

    // core_rst pulse-length monitor.
    always @(negedge clk) begin
        if (core_rst) rst_run++;
        else if (rst_run != 0) begin
            chk("core_rst_len", rst_run, CLR_CYC);
            rst_run = 0;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_core_rst"}, core_rst, 0);
        chk({tag, "_core_pix"}, core_pix, 0);
        chk({tag, "_core_pix_vld"}, core_pix_vld, 0);
        chk({tag, "_core_load_end"}, core_load_end, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_edge_cnt"}, edge_cnt, 0);
        chk({tag, "_cnt_valid"}, cnt_valid, 0);
        chk({tag, "_tile_idx"}, tile_idx, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_ovf"}, err_ovf, 0);
    endtask

    task automatic apply_reset();
        src_valid     = 1'b0;
        core_readable = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        beat_q.delete();
        word_q.delete();
        stat_q.delete();
        err_exp    = 1'b0;
        tiles_done = 0;
        last_cnt   = '0;
        repeat (3) @(negedge clk);
        check_zero("rst_held");
        reset_n = 1'b1;
    endtask

    // One tile: vgap/rgap are percent idle cycles on src_valid/core_readable.
    task automatic run_tile(input int vgap, input int rgap, input bit ones,
                            input bit inject, input int abort_at);
        int            beats, bits, cyc, ones_cnt;
        logic [PACK_W-1:0] w;
        bit            v, r, b;
        beat_t         bt;
        word_t         wt;
        stat_t         st;
        pix_seen = 0;
        beats    = 0;
        cyc      = 0;
        while (beats < IN_BEATS && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            v = ($urandom_range(99) >= vgap);
            src_valid     = v;
            src_pix       = PW'($urandom);
            core_readable = 1'b0;
            if (inject && beats == IN_BEATS / 2 && src_ready) begin
                core_readable = 1'b1;
                core_edge     = 1'b1;
                err_exp       = 1'b1;
                inject        = 1'b0;
            end
            if (v && src_ready) begin
                bt.pix  = src_pix;
                bt.last = (beats == IN_BEATS - 1);
                beat_q.push_back(bt);
                beats++;
            end
        end
        if (beats < IN_BEATS) fail("load_timeout");

        @(negedge clk);
        src_valid     = 1'b0;
        core_readable = 1'b0;
        chk("src_ready_after_load", src_ready, 0);
        chk("edge_cnt_held", edge_cnt, last_cnt);
        chk("tile_idx_held", tile_idx, 16'(tiles_done));

        bits     = 0;
        ones_cnt = 0;
        w        = '0;
        cyc      = 0;
        while (bits < OUT_BEATS && cyc < 6000) begin
            if (abort_at >= 0 && bits == abort_at) begin
                apply_reset();
                return;
            end
            r = ($urandom_range(99) >= rgap);
            b = ones ? 1'b1 : 1'($urandom_range(1));
            core_readable = r;
            core_edge     = b;
            if (r) begin
                w[bits % PACK_W] = b;
                ones_cnt += int'(b);
                if ((bits % PACK_W) == PACK_W - 1 || bits == OUT_BEATS - 1) begin
                    wt.data = w;
                    wt.last = (bits == OUT_BEATS - 1);
                    word_q.push_back(wt);
                    w = '0;
                end
                if (bits == OUT_BEATS - 1) begin
                    st.cnt = CW'(ones_cnt);
                    st.idx = 16'(tiles_done + 1);
                    stat_q.push_back(st);
                end
                bits++;
            end
            @(negedge clk);
            cyc++;
        end
        core_readable = 1'b0;
        if (bits < OUT_BEATS) fail("drain_timeout");

        cyc = 0;
        while ((word_q.size() != 0 || stat_q.size() != 0) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (word_q.size() != 0 || stat_q.size() != 0) fail("output_timeout");
        @(negedge clk);
        tiles_done++;
        last_cnt = CW'(ones_cnt);
        chk("core_pix_vld_count", pix_seen, IN_BEATS);
        chk("err_ovf", err_ovf, err_exp);
        chk("done", done, (tiles_done == TILES));
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        run_tile(0, 0, 1'b1, 1'b0, -1);     // held valid, all-ones edges
        run_tile(50, 30, 1'b0, 1'b1, -1);   // gaps plus stray readable in LOAD
        run_tile(50, 20, 1'b0, 1'b0, 100);  // reset mid-DRAIN
        run_tile(0, 0, 1'b1, 1'b0, -1);
        run_tile(50, 50, 1'b0, 1'b0, -1);
        run_tile(30, 10, 1'b0, 1'b0, -1);   // third tile reaches the limit

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            src_valid = 1'b1;
            src_pix   = PW'($urandom);
            chk("src_ready_in_done", src_ready, 0);
            if (i == 29) chk("done_sticky", done, 1);
        end
        src_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tile_seq_ctrl.md
TILE_SEQ_CTRL -- requirements
Module: tile_seq_ctrl

Interface
REQ-001 Parameters SHALL be: LANES, default 5, pixel lanes per beat; PIX_W, default 5, bits per pixel; IN_BEATS, default 80, input beats per tile; OUT_BEATS, default 324, edge bits per tile; PACK_W, default 8, edge bits per output word; CLR_CYC, default 2, core-clear cycles; TILES, default 0, tile limit (0 = unlimited).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port src_valid, input, 1: source beat valid.
REQ-006 Port src_ready, output, 1: beat accepted when src_valid && src_ready.
REQ-007 Port src_pix, input, LANES*PIX_W: lane 0 in the LSBs.
REQ-008 Port core_rst, output, 1: active-high clear to the edge core.
REQ-009 Port core_pix, output, LANES*PIX_W: registered pixel beat.
REQ-010 Port core_pix_vld, output, 1: core_pix valid this cycle.
REQ-011 Port core_load_end, output, 1: tile fully loaded.
REQ-012 Port core_readable, input, 1: core_edge valid this cycle.
REQ-013 Port core_edge, input, 1: edge result bit.
REQ-014 Port out_valid, output, 1: one-cycle strobe; no backpressure.
REQ-015 Port out_data, output, PACK_W: packed edge bits, first bit in the LSB.
REQ-016 Port out_last, output, 1: final word of the tile.
REQ-017 Port edge_cnt, output, clog2(OUT_BEATS+1): number of 1 edge bits in the last tile.
REQ-018 Port cnt_valid, output, 1: one-cycle strobe for edge_cnt.
REQ-019 Port tile_idx, output, 16: tiles completed, wraps at 2^16.
REQ-020 Port done, output, 1: tile limit reached.
REQ-021 Port err_ovf, output, 1: sticky protocol error.

Function
REQ-022 The FSM SHALL have states IDLE, CLEAR, LOAD, DRAIN, FLUSH, DONE.
REQ-023 IDLE SHALL move to CLEAR when src_valid is 1; src_ready SHALL be 0 in IDLE.
REQ-024 CLEAR SHALL hold core_rst=1 for exactly CLR_CYC cycles, deassert core_load_end, zero the beat, bit and edge counters, then enter LOAD.
REQ-025 LOAD SHALL set src_ready=1 and accept up to IDLE-independent IN_BEATS beats; a beat accepted at cycle t SHALL appear on core_pix with core_pix_vld=1 at t+1.
REQ-026 The IN_BEATS-th beat SHALL present core_load_end=1 alongside its core_pix, hold it through DRAIN, then move the FSM to DRAIN.
REQ-027 src_valid gaps in LOAD SHALL insert core_pix_vld=0 cycles; core_pix SHALL hold its last value.
REQ-028 DRAIN SHALL keep src_ready=0, shift each core_edge with core_readable=1 into the pack register, and add it to the edge count.
REQ-029 Each full PACK_W group SHALL produce out_valid=1 for one cycle on the cycle after the completing bit.
REQ-030 When the OUT_BEATS-th bit is taken, DRAIN SHALL enter FLUSH.
REQ-031 FLUSH (one cycle) SHALL emit any partial word zero-padded in the MSBs with out_last=1, or set out_last on the already-emitted final full word; it SHALL pulse cnt_valid, increment tile_idx, and go to CLEAR, or to DONE when TILES!=0 and tile_idx reaches TILES.
REQ-032 The tile SHALL yield exactly ceil(OUT_BEATS/PACK_W) out_valid strobes, with exactly one out_last.
REQ-033 DONE SHALL set done=1 and src_ready=0, and hold until reset.
REQ-034 core_readable=1 outside DRAIN SHALL set err_ovf; that bit SHALL be ignored.
REQ-035 src_valid in IDLE with TILES reached SHALL NOT occur, since the FSM is in DONE.
REQ-036 edge_cnt SHALL update only at FLUSH and hold between tiles.

Reset
REQ-037 reset_n=0 SHALL asynchronously force IDLE and clear all counters and the pack register, at any state including mid-LOAD or mid-DRAIN.
REQ-038 During reset, src_ready, core_rst, core_pix, core_pix_vld, core_load_end, out_valid, out_data, out_last, edge_cnt, cnt_valid, tile_idx, done and err_ovf SHALL all be 0.
REQ-039 No partial word SHALL be emitted on reset.

Structure
REQ-040 A shared package SHALL hold the state enum, the default parameter values and a clog2 helper.
REQ-041 A single sub-module, edge_packer, SHALL implement the shift, pad and strobe logic for the pack register (REQ-028 to REQ-031).

Verification
REQ-042 Defaults, one tile, src_valid held high -> core_rst high 2 cycles; 80 core_pix_vld; core_load_end with beat 80; src_ready low after beat 80.
REQ-043 Feed 324 core_edge=1 bits -> 40 words of 0xFF then 0x0F with out_last; edge_cnt=324; tile_idx=1.
REQ-044 Random src_valid gaps (50%) -> core_pix sequence identical to the accepted beats, in order; exactly 80 valids.
REQ-045 TILES=3, 3 tiles streamed -> done=1 after the third FLUSH; further src_valid stays unaccepted.
REQ-046 core_readable pulse during LOAD -> err_ovf=1 sticky; edge_cnt unaffected.
REQ-047 reset_n low at DRAIN bit 100 -> all outputs 0 immediately; next tile behaves as in REQ-042.
